// File: rtl/cache_mem_responder.sv
// Line-granular backing store for the cache: one transaction at a time, mem_ready pulses LATENCY edges after acceptance.
// Registered outputs only; busy covers acceptance through the mem_ready cycle, and completed reads/writes are counted.
module cache_mem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         busy,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [127:0]           r_wdata;
    logic                   r_is_wr;
    logic [127:0]           r_mem [0:(1<<ADDR_BITS)-1];

    logic w_req;
    logic w_commit_wr;
    logic w_unused_addr;

    assign w_req         = mem_read | mem_write;
    assign w_commit_wr   = (r_state == WAIT) && (r_cnt == 4'd0) && r_is_wr && !proc_reset;
    assign w_unused_addr = ^mem_addr[27:ADDR_BITS];

    // Array has no reset; a write whose commit edge sees reset is dropped.
    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            mem_rdata <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            case (r_state)
                // The RESP edge doubles as an IDLE edge so a request raised after
                // mem_ready is taken immediately, giving LATENCY+1 cycle throughput.
                IDLE, RESP: begin
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                    if (w_req) begin
                        r_idx   <= mem_addr[ADDR_BITS-1:0];
                        r_wdata <= mem_wdata;
                        r_is_wr <= mem_write;
                        r_cnt   <= CNT_INIT;
                        busy    <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                // With LATENCY=1 the counter starts at 0, so WAIT lasts a single
                // cycle and mem_ready still lands exactly LATENCY edges after acceptance.
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= RESP;
                        mem_ready <= 1'b1;
                        if (r_is_wr) begin
                            wr_count <= (wr_count == 32'hFFFF_FFFF) ? wr_count : wr_count + 32'd1;
                        end else begin
                            mem_rdata <= r_mem[r_idx];
                            rd_count  <= (rd_count == 32'hFFFF_FFFF) ? rd_count : rd_count + 32'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
